// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter:
// register map, STATUS bit positions and TX FSM state encodings.
package uart_tx_buffered_pkg;

    localparam int WORD_LEN = 32;

    localparam logic [WORD_LEN-1:0] UART_TXDATA_OFS = 32'h0;
    localparam logic [WORD_LEN-1:0] UART_STATUS_OFS = 32'h4;
    localparam int UART_REG_SEL_BIT = 2;

    localparam int UART_ST_FULL    = 0;
    localparam int UART_ST_EMPTY   = 1;
    localparam int UART_ST_BUSY    = 2;
    localparam int UART_ST_OVF     = 3;
    localparam int UART_ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with combinational head (dout valid while !empty).
// Push is accepted when not full, or when full and popped in the same cycle.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte writes queue in a FIFO, STATUS read has 1-cycle latency.
// Line goes low 1 cycle after the write edge; writes to a full FIFO without a pop are dropped and flagged.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int WAIT_DIV = 104,
    parameter int DEPTH    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_LEN-1:0] addr,
    input  logic                wen,
    input  logic [WORD_LEN-1:0] wdata,
    output logic [WORD_LEN-1:0] rdata,
    output logic                uart_out
);
    localparam int CNT_W = $clog2(WAIT_DIV);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WAIT_DIV - 1);

    tx_state_t         state;
    logic [CNT_W-1:0]  baud_cnt;
    logic [2:0]        bitcnt;
    logic [7:0]        shreg;
    logic              overflow;

    logic              sel_status;
    logic              push;
    logic              pop;
    logic              ovf_clr;
    logic              baud_zero;
    logic [7:0]        fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [31:0]       cnt_ext;
    logic [3:0]        cnt_sat;
    logic [WORD_LEN-1:0] status;
    logic              unused_bits;

    assign sel_status  = addr[UART_REG_SEL_BIT];
    assign push        = wen && !sel_status;
    assign ovf_clr     = wen && sel_status && wdata[UART_ST_OVF];
    assign baud_zero   = (baud_cnt == '0);
    assign unused_bits = ^{addr[WORD_LEN-1:UART_REG_SEL_BIT+1], addr[UART_REG_SEL_BIT-1:0],
                           wdata[WORD_LEN-1:8]};

    // Pop on the same edge that launches a start bit, so STOP chains directly into START.
    assign pop = !fifo_empty && ((state == TX_IDLE) || (state == TX_STOP && baud_zero));

    uart_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        cnt_ext = 32'(fifo_count);
        cnt_sat = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
        status                           = '0;
        status[UART_ST_FULL]             = fifo_full;
        status[UART_ST_EMPTY]            = fifo_empty;
        status[UART_ST_BUSY]             = (state != TX_IDLE);
        status[UART_ST_OVF]              = overflow;
        status[UART_ST_CNT_LSB +: 4]     = cnt_sat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            uart_out <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        shreg    <= fifo_dout;
                        baud_cnt <= RELOAD;
                        uart_out <= 1'b0;
                        state    <= TX_START;
                    end
                end
                TX_START: begin
                    if (baud_zero) begin
                        baud_cnt <= RELOAD;
                        bitcnt   <= '0;
                        uart_out <= shreg[0];
                        state    <= TX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (baud_zero) begin
                        shreg    <= {1'b0, shreg[7:1]};
                        baud_cnt <= RELOAD;
                        if (bitcnt == 3'd7) begin
                            uart_out <= 1'b1;
                            state    <= TX_STOP;
                        end else begin
                            bitcnt   <= bitcnt + 1'b1;
                            uart_out <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                TX_STOP: begin
                    if (baud_zero) begin
                        if (!fifo_empty) begin
                            shreg    <= fifo_dout;
                            baud_cnt <= RELOAD;
                            uart_out <= 1'b0;
                            state    <= TX_START;
                        end else begin
                            uart_out <= 1'b1;
                            state    <= TX_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    // Set wins over a same-cycle software clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (push && fifo_full && !pop)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else
            rdata <= sel_status ? status : '0;
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: stimulus queues expected frames/reads,
// independent monitors decode the serial line and registered read data.
module tb_uart_tx_buffered;
    import uart_tx_buffered_pkg::*;

    localparam int WD    = 4;
    localparam int DP    = 4;
    localparam int FRAME = 10 * WD;

    typedef struct {
        logic [7:0] data;
        int         t_start;
        bit         aborted;
    } frame_t;

    typedef struct {
        string         name;
        logic [31:0]   exp;
    } rd_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [WORD_LEN-1:0] addr = '0;
    logic                wen = 1'b0;
    logic [WORD_LEN-1:0] wdata = '0;
    logic [WORD_LEN-1:0] rdata;
    logic                uart_out;

    logic rd_req = 1'b0;
    logic rd_req_q = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    frame_t frm_q[$];
    rd_t    rd_q[$];

    uart_tx_buffered #(.WAIT_DIV(WD), .DEPTH(DP)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wen      (wen),
        .wdata    (wdata),
        .rdata    (rdata),
        .uart_out (uart_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_req_q <= rd_req;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Write sampled on edge e (the next rising edge).
    task automatic do_write(input logic [31:0] ofs, input logic [31:0] d, output int e);
        e     = cyc + 1;
        addr  = ofs;
        wdata = d;
        wen   = 1'b1;
        @(negedge clk);
        wen   = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [31:0] ofs, input logic [31:0] exp);
        rd_q.push_back('{name: name, exp: exp});
        addr   = ofs;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic exp_frame(input logic [7:0] d, input int t, input bit ab);
        frm_q.push_back('{data: d, t_start: t, aborted: ab});
    endtask

    // Read monitor: rdata is checked the cycle after a requested read.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_req_q) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected: got 0x%08h with no expectation", rdata);
                end else begin
                    check(rd_q[0].name, rdata, rd_q[0].exp);
                    void'(rd_q.pop_front());
                end
            end
        end
    end

    // Serial monitor: detects start bits, samples each bit mid-period.
    frame_t     m_exp;
    bit         m_have;
    bit         m_abort;
    int         m_t0;
    logic [9:0] m_bits;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && uart_out === 1'b1 && frm_q.size() > 0 && cyc > frm_q[0].t_start) begin
                checks++;
                failures++;
                $display("FAIL frame_timeout: no start bit by cycle %0d, required at %0d",
                         cyc, frm_q[0].t_start);
                void'(frm_q.pop_front());
            end else if (!rst && uart_out === 1'b0) begin
                m_t0   = cyc;
                m_have = (frm_q.size() > 0);
                if (m_have) begin
                    m_exp = frm_q.pop_front();
                    check("frame_start_cycle", m_t0, m_exp.t_start);
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL frame_unexpected: start bit at cycle %0d, none required", m_t0);
                end
                m_abort = 1'b0;
                m_bits  = '0;
                for (int i = 0; i < 10; i++) begin
                    while (cyc < m_t0 + WD * i + 2 && !rst) @(negedge clk);
                    if (rst) begin
                        m_abort = 1'b1;
                        break;
                    end
                    m_bits[i] = uart_out;
                end
                if (m_have) begin
                    check("frame_abort", {31'b0, m_abort}, {31'b0, m_exp.aborted});
                    if (!m_abort && !m_exp.aborted)
                        check("frame_bits", {22'b0, m_bits}, {22'b0, 1'b1, m_exp.data, 1'b0});
                end
                while (rst) @(negedge clk);
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not complete within cycle budget");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int e0;

        #12;
        check("rst_line", {31'b0, uart_out}, 32'h1);
        check("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Read latency, idle and empty.
        do_read("rd_idle_status", UART_STATUS_OFS, 32'h2);
        do_read("rd_txdata", UART_TXDATA_OFS, 32'h0);

        // Single byte.
        do_write(UART_TXDATA_OFS, 32'h55, e0);
        exp_frame(8'h55, e0 + 1, 1'b0);
        wait_cyc(e0 + 9);
        do_read("rd_single_busy", UART_STATUS_OFS, 32'h6);
        wait_cyc(e0 + 41);
        do_read("rd_single_done", UART_STATUS_OFS, 32'h2);

        // Burst of three, frames back to back.
        do_write(UART_TXDATA_OFS, 32'h01, e0);
        exp_frame(8'h01, e0 + 1, 1'b0);
        do_write(UART_TXDATA_OFS, 32'h02, e);
        exp_frame(8'h02, e0 + 1 + FRAME, 1'b0);
        do_write(UART_TXDATA_OFS, 32'h03, e);
        exp_frame(8'h03, e0 + 1 + 2 * FRAME, 1'b0);
        do_read("rd_burst", UART_STATUS_OFS, 32'h24);
        wait_cyc(e0 + 3 * FRAME + 4);
        do_read("rd_burst_done", UART_STATUS_OFS, 32'h2);

        // Overflow: six writes, fifth fills, sixth is dropped.
        e0 = 0;
        for (int i = 0; i < 6; i++) begin
            do_write(UART_TXDATA_OFS, 32'hA0 + 32'(i), e);
            if (i == 0) e0 = e;
            if (i < 5) exp_frame(8'hA0 + 8'(i), e0 + 1 + FRAME * i, 1'b0);
        end
        do_read("rd_ovf_set", UART_STATUS_OFS, 32'h4D);
        do_write(UART_STATUS_OFS, 32'h8, e);
        do_read("rd_ovf_clr", UART_STATUS_OFS, 32'h45);
        wait_cyc(e0 + 5 * FRAME + 4);
        do_read("rd_ovf_done", UART_STATUS_OFS, 32'h2);

        // Full FIFO with a write landing on the stop-bit pop edge.
        do_write(UART_TXDATA_OFS, 32'hB0, e0);
        exp_frame(8'hB0, e0 + 1, 1'b0);
        for (int i = 1; i < 5; i++) begin
            do_write(UART_TXDATA_OFS, 32'hB0 + 32'(i), e);
            exp_frame(8'hB0 + 8'(i), e0 + 1 + FRAME * i, 1'b0);
        end
        do_read("rd_full", UART_STATUS_OFS, 32'h45);
        wait_cyc(e0 + 40);
        do_write(UART_TXDATA_OFS, 32'hB5, e);
        check("full_pop_edge", e, e0 + 41);
        exp_frame(8'hB5, e0 + 1 + 5 * FRAME, 1'b0);
        do_read("rd_full_pop", UART_STATUS_OFS, 32'h45);
        wait_cyc(e0 + 6 * FRAME + 4);
        do_read("rd_full_done", UART_STATUS_OFS, 32'h2);

        // Reset during data bit 3 with two bytes queued.
        do_write(UART_TXDATA_OFS, 32'hC0, e0);
        exp_frame(8'hC0, e0 + 1, 1'b1);
        do_write(UART_TXDATA_OFS, 32'hC1, e);
        do_write(UART_TXDATA_OFS, 32'hC2, e);
        wait_cyc(e0 + 16);
        addr = UART_STATUS_OFS;
        wait_cyc(e0 + 18);
        check("pre_rst_line", {31'b0, uart_out}, 32'h0);
        check("pre_rst_rdata", rdata, 32'h24);
        #2 rst = 1'b1;
        #1;
        check("async_rst_line", {31'b0, uart_out}, 32'h1);
        check("async_rst_rdata", rdata, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_read("rd_after_rst", UART_STATUS_OFS, 32'h2);
        repeat (100) @(negedge clk);
        check("rd_after_rst_line", {31'b0, uart_out}, 32'h1);

        check("frames_pending", frm_q.size(), 32'h0);
        check("reads_pending", rd_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
